// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready holding register.
// The serial line is synchronised into the clk domain and bit timing is
// re-derived from each start edge with a local baud counter.
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. Without it, o_parity_err is tied to 0.

module uart_rx #(
    parameter int CLKS_PER_BIT = 500,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // The edge-detect cycle and the IDLE->START cycle already cover two of
    // the half-bit cycles, so START compares against half-2.
    localparam logic [CW-1:0] LP_HALF_LAST = CW'((CLKS_PER_BIT / 2) - 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_bit_tick;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_stop_seen;
    logic                   r_stop_bit;

    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad;
    logic                   r_parity_err;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_bit_tick = (r_cnt == LP_BIT_LAST);

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

    // Metastability synchroniser for rx plus a delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_prev <= w_rx_s;
        end
    end

    // Receive FSM, baud counter, deframing and the output holding register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_stop_seen <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses.
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // Consumer handshake; a simultaneous load below overrides this.
            if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end else begin
                r_rx_valid <= r_rx_valid;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt       <= '0;
                    r_stop_seen <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    r_par_bad   <= 1'b0;
`endif
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (r_cnt == LP_HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // Line went back high before mid-start: glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_cnt     <= '0;
                        r_par_bad <= (w_rx_s != even_parity(r_shift));
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (r_stop_seen) begin
                        // Stop bit was sampled last cycle: resolve the frame.
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_stop_seen <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) begin
                            r_parity_err <= 1'b1;
                        end else
`endif
                        if (!r_stop_bit) begin
                            r_frame_err <= 1'b1;
                        end else if (r_rx_valid && !i_rx_ready) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_bit_tick) begin
                        r_cnt       <= '0;
                        r_stop_seen <= 1'b1;
                        r_stop_bit  <= w_rx_s;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLKS_PER_BIT=16, SYNC_STAGES=2.
// Frame start (rx falling) is driven 1 time unit after a posedge, called cycle 0.

module tb_uart_rx;

    localparam int CPB = 16;
    // Valid rises 9.5 bit periods + 2 sync flops + 1 cycle after the start edge:
    // 8N1 -> 152+2+1 = 155; with the parity bit 10.5*16 = 168 -> 171.
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] rx_data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       perr;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc, rises, first_rise, n_ferr, n_ovr, n_perr, busy_seen;
    int ready_pulse_at = -1;
    logic prev_valid;
`ifdef UART_RX_PARITY_EN
    logic flip_par = 1'b0;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx         (rx),
        .o_rx_data    (rx_data),
        .o_rx_valid   (valid),
        .i_rx_ready   (ready),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_parity_err (perr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cyc = 0; rises = 0; first_rise = -1;
        n_ferr = 0; n_ovr = 0; n_perr = 0; busy_seen = 0;
        prev_valid = valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid && !prev_valid) begin
            rises++;
            if (first_rise < 0) first_rise = cyc;
        end
        prev_valid = valid;
        n_ferr += int'(ferr);
        n_ovr  += int'(ovr);
        n_perr += int'(perr);
        if (busy) busy_seen = 1;
        if (ready_pulse_at >= 0) ready = (cyc == ready_pulse_at - 1);
    endtask

    task automatic drive(input logic lvl, input int n);
        rx = lvl;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ flip_par, CPB);
`endif
        drive(stop, CPB);
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  32'(rx_data), 32'h00);
        chk("rst_valid", 32'(valid),   32'h0);
        chk("rst_ferr",  32'(ferr),    32'h0);
        chk("rst_ovr",   32'(ovr),     32'h0);
        chk("rst_perr",  32'(perr),    32'h0);
        chk("rst_busy",  32'(busy),    32'h0);
        rst_n = 1'b1;
        drive(1'b1, 5);

        // 0xA5 with the consumer always ready: one valid pulse at LAT.
        ready = 1'b1;
        clr_mon();
        send(8'hA5, 1'b1);
        drive(1'b1, 30);
        chk("a5_rises", 32'(rises),      32'd1);
        chk("a5_lat",   32'(first_rise), 32'(LAT));
        chk("a5_data",  32'(rx_data),    32'hA5);
        chk("a5_valid", 32'(valid),      32'h0);
        chk("a5_flags", 32'(n_ferr + n_ovr + n_perr), 32'd0);
        chk("a5_busy_seen", 32'(busy_seen), 32'd1);
        chk("a5_busy_end",  32'(busy),      32'h0);

        // 3-cycle low glitch: start bit rejected, no flags.
        clr_mon();
        drive(1'b0, 3);
        drive(1'b1, 40);
        chk("gl_busy_seen", 32'(busy_seen), 32'd1);
        chk("gl_busy_end",  32'(busy),      32'h0);
        chk("gl_rises",     32'(rises),     32'd0);
        chk("gl_flags",     32'(n_ferr + n_ovr + n_perr), 32'd0);

        // 0x3C with a low stop bit: one frame_err pulse, nothing loaded.
        clr_mon();
        send(8'h3C, 1'b0);
        drive(1'b1, 30);
        chk("fe_ferr",  32'(n_ferr),  32'd1);
        chk("fe_rises", 32'(rises),   32'd0);
        chk("fe_data",  32'(rx_data), 32'hA5);
        chk("fe_perr",  32'(n_perr),  32'd0);

        // Break: line low for a long time gives a single frame_err.
        clr_mon();
        send(8'h00, 1'b0);
        drive(1'b0, 60);
        drive(1'b1, 30);
        chk("brk_ferr",  32'(n_ferr), 32'd1);
        chk("brk_rises", 32'(rises),  32'd0);
        chk("brk_busy",  32'(busy),   32'h0);

        // Consumer stalled: 0x11 is held, 0x22 overruns and is dropped.
        ready = 1'b0;
        clr_mon();
        send(8'h11, 1'b1);
        drive(1'b1, 30);
        chk("ov1_rises", 32'(rises),   32'd1);
        chk("ov1_data",  32'(rx_data), 32'h11);
        clr_mon();
        send(8'h22, 1'b1);
        drive(1'b1, 30);
        chk("ov2_ovr",   32'(n_ovr),   32'd1);
        chk("ov2_data",  32'(rx_data), 32'h11);
        chk("ov2_valid", 32'(valid),   32'h1);

        // Accept in the same cycle as the next load: new byte, no overrun.
        clr_mon();
        ready_pulse_at = LAT;
        send(8'h22, 1'b1);
        drive(1'b1, 30);
        ready_pulse_at = -1;
        chk("sc_ovr",   32'(n_ovr),   32'd0);
        chk("sc_data",  32'(rx_data), 32'h22);
        chk("sc_valid", 32'(valid),   32'h1);

        // Reset in the middle of data bit 4 of 0x5A.
        clr_mon();
        drive(1'b0, CPB);
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b1, 8);
        chk("mid_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(valid),   32'h0);
        chk("mid_data",  32'(rx_data), 32'h00);
        chk("mid_busy",  32'(busy),    32'h0);
        rx = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready = 1'b1;
        drive(1'b1, 10);
        clr_mon();
        send(8'h5A, 1'b1);
        drive(1'b1, 30);
        chk("post_rises", 32'(rises),      32'd1);
        chk("post_lat",   32'(first_rise), 32'(LAT));
        chk("post_data",  32'(rx_data),    32'h5A);
        chk("post_flags", 32'(n_ferr + n_ovr + n_perr), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        flip_par = 1'b0;
        clr_mon();
        send(8'h07, 1'b1);
        drive(1'b1, 30);
        chk("par_ok_rises", 32'(rises),   32'd1);
        chk("par_ok_data",  32'(rx_data), 32'h07);
        chk("par_ok_perr",  32'(n_perr),  32'd0);
        flip_par = 1'b1;
        clr_mon();
        send(8'h07, 1'b1);
        drive(1'b1, 30);
        flip_par = 1'b0;
        chk("par_bad_perr",  32'(n_perr), 32'd1);
        chk("par_bad_rises", 32'(rises),  32'd0);
        chk("par_bad_ferr",  32'(n_ferr), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
